// File: rtl/taylor_pkg.sv
// Shared definitions for the Taylor-series function engines (arcsine now,
// sine later): FSM states, series coefficients and result saturation.
package taylor_pkg;

  typedef enum logic [3:0] {
    S_INIT,
    S_GET_INPUT,
    S_BYPASS,
    S_SQUARE,
    S_MULT,
    S_ACCUM,
    S_NEXT_POWER,
    S_RESCALE,
    S_SEND_OUTPUT
  } state_t;

  localparam int C_ASIN_TERMS = 4;

  // asin(x) ~ x + x^3/6 + 3x^5/40 + 15x^7/336
  localparam real C_ASIN_REAL [C_ASIN_TERMS] = '{1.0, 1.0/6.0, 3.0/40.0, 15.0/336.0};

  // Coefficient k quantised to Q2.(tapwidth-2), round to nearest.
  function automatic int asin_coef(input int k, input int tapwidth);
    return $rtoi(C_ASIN_REAL[k] * (2.0 ** (tapwidth - 2)) + 0.5);
  endfunction

  // Clamp v to the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/arcsine_taylor.sv
// Streaming fixed-point arcsine: 4-term Maclaurin series evaluated
// iteratively through one shared signed multiplier. Q1 in, Q2 out.
module arcsine_taylor
  import taylor_pkg::*;
#(
  parameter int G_DWIDTH   = 16,
  parameter int G_TAPWIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       bypass,
  input  logic signed [G_DWIDTH-1:0] din,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic signed [G_DWIDTH-1:0] dout,
  output logic                       dout_valid,
  input  logic                       dout_ready
);

  localparam int TW  = G_DWIDTH + G_TAPWIDTH;  // term width
  localparam int AW  = TW + 2;                 // accumulator width (4 terms of headroom)
  localparam int MBW = (G_TAPWIDTH > G_DWIDTH + 1) ? G_TAPWIDTH : G_DWIDTH + 1;
  localparam int PRW = G_DWIDTH + MBW;         // shared product width
  localparam logic [1:0] K_LAST = 2'(C_ASIN_TERMS - 1);

  localparam logic signed [G_TAPWIDTH-1:0] COEF [C_ASIN_TERMS] = '{
    G_TAPWIDTH'(asin_coef(0, G_TAPWIDTH)),
    G_TAPWIDTH'(asin_coef(1, G_TAPWIDTH)),
    G_TAPWIDTH'(asin_coef(2, G_TAPWIDTH)),
    G_TAPWIDTH'(asin_coef(3, G_TAPWIDTH))
  };

  state_t state, state_next;

  logic signed [G_DWIDTH-1:0] x;     // latched sample
  logic signed [G_DWIDTH-1:0] p;     // current odd power x^(2k+1)
  logic signed [G_DWIDTH:0]   x2;    // x^2, one extra bit so (-1)^2 = +1.0 fits
  logic signed [TW-1:0]       term;
  logic signed [AW-1:0]       acc;
  logic [1:0]                 k;

  logic signed [G_DWIDTH-1:0] mul_a;
  logic signed [MBW-1:0]      mul_b;
  logic signed [PRW-1:0]      prod;
  logic signed [PRW-1:0]      prod_shr;
  logic signed [AW-1:0]       acc_shr;
  logic signed [63:0]         sat_full;
  logic signed [G_DWIDTH-1:0] dout_sat;
  logic                       clr;
  logic                       unused_bits;

  // enable=0 behaves exactly like reset
  assign clr = !reset || !enable;

  // Operand steering for the single shared multiplier
  always_comb begin
    mul_a = p;
    mul_b = MBW'(x2);
    case (state)
      S_SQUARE: begin mul_a = x; mul_b = MBW'(x); end
      S_MULT:   begin mul_a = p; mul_b = MBW'(COEF[k]); end
      default:  ;
    endcase
  end

  assign prod     = PRW'(mul_a) * PRW'(mul_b);
  assign prod_shr = prod >>> (G_DWIDTH - 1);
  assign acc_shr  = acc >>> (G_TAPWIDTH - 1);
  assign sat_full = sat_signed(64'(acc_shr), G_DWIDTH);
  assign dout_sat = sat_full[G_DWIDTH-1:0];
  assign unused_bits = ^{prod_shr[PRW-1:G_DWIDTH+1], sat_full[63:G_DWIDTH]};

  // State register
  always_ff @(posedge clk) begin
    if (clr) state <= S_INIT;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_INIT:        state_next = S_GET_INPUT;
      S_GET_INPUT:   if (din_valid) state_next = bypass ? S_BYPASS : S_SQUARE;
      S_BYPASS:      state_next = S_SEND_OUTPUT;
      S_SQUARE:      state_next = S_MULT;
      S_MULT:        state_next = S_ACCUM;
      S_ACCUM:       state_next = (k == K_LAST) ? S_RESCALE : S_NEXT_POWER;
      S_NEXT_POWER:  state_next = S_MULT;
      S_RESCALE:     state_next = S_SEND_OUTPUT;
      S_SEND_OUTPUT: if (dout_ready) state_next = S_GET_INPUT;
      default:       state_next = S_INIT;
    endcase
  end

  // Handshake outputs decode straight from the state
  always_comb begin
    din_ready  = (state == S_GET_INPUT);
    dout_valid = (state == S_SEND_OUTPUT);
  end

  // Datapath: one multiply per state, accumulate, rescale
  always_ff @(posedge clk) begin
    if (clr) begin
      x    <= '0;
      p    <= '0;
      x2   <= '0;
      term <= '0;
      acc  <= '0;
      k    <= '0;
      dout <= '0;
    end else begin
      case (state)
        S_GET_INPUT: if (din_valid) begin
          x   <= din;
          p   <= din;
          acc <= '0;
          k   <= '0;
        end
        S_BYPASS:     dout <= x >>> 1;
        S_SQUARE:     x2   <= prod_shr[G_DWIDTH:0];
        S_MULT:       term <= prod[TW-1:0];
        S_ACCUM: begin
          acc <= acc + AW'(term);
          if (k != K_LAST) k <= k + 2'd1;
        end
        S_NEXT_POWER: p    <= prod_shr[G_DWIDTH-1:0];
        S_RESCALE:    dout <= dout_sat;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arcsine_taylor.sv
// Directed bench for arcsine_taylor (G_DWIDTH=16, G_TAPWIDTH=16).
module tb_arcsine_taylor;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               enable = 1'b1;
  logic               bypass = 1'b0;
  logic signed [15:0] din = '0;
  logic               din_valid = 1'b0;
  logic               din_ready;
  logic signed [15:0] dout;
  logic               dout_valid;
  logic               dout_ready = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  arcsine_taylor #(.G_DWIDTH(16), .G_TAPWIDTH(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bypass(bypass),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  // Offer one sample, then count edges after acceptance until dout_valid.
  // lat=-1 means no result within the cycle budget.
  task automatic send(input logic signed [15:0] xv, input logic byp,
                      output int lat, output logic rdy_leak);
    int n;
    n = 0;
    rdy_leak = 1'b0;
    while (din_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    din = xv; bypass = byp; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0; bypass = 1'b0;
    lat = -1;
    for (int e = 1; e <= 40; e++) begin
      if (din_ready !== 1'b0) rdy_leak = 1'b1;
      @(posedge clk); #1;
      if (dout_valid === 1'b1) begin lat = e; break; end
    end
  endtask

  task automatic release_out();
    dout_ready = 1'b1;
    @(posedge clk); #1;
    dout_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_dout_valid: got %b want 0", dout_valid); end
    total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL reset_din_ready: got %b want 0", din_ready); end
    total++; if (dout !== 16'sd0) begin bad++; $display("FAIL reset_dout: got %0d want 0", dout); end
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL init_din_ready: got %b want 1", din_ready); end
  endtask

  task automatic test_series();
    logic signed [15:0] xs  [5] = '{16'sd0, 16'sd16384, -16'sd16384, -16'sd32768, 16'sd32767};
    logic signed [15:0] exs [5] = '{16'sd0, 16'sd8577, -16'sd8578, -16'sd21075, 16'sd21073};
    int lat;
    logic leak;
    for (int i = 0; i < 5; i++) begin
      send(xs[i], 1'b0, lat, leak);
      total++; if (lat != 13) begin bad++; $display("FAIL series_latency x=%0d: got %0d want 13", xs[i], lat); end
      total++; if (dout !== exs[i]) begin bad++; $display("FAIL series_dout x=%0d: got %0d want %0d", xs[i], dout, exs[i]); end
      total++; if (leak !== 1'b0 || din_ready !== 1'b0) begin bad++; $display("FAIL series_din_ready_low x=%0d: got leak=%b rdy=%b want 0", xs[i], leak, din_ready); end
      release_out();
      total++; if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin bad++; $display("FAIL series_handshake x=%0d: got vld=%b rdy=%b want 0/1", xs[i], dout_valid, din_ready); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic leak;
    int errs;
    send(16'sd16384, 1'b0, lat, leak);
    total++; if (lat != 13 || dout !== 16'sd8577) begin bad++; $display("FAIL bp_first: got lat=%0d dout=%0d want 13/8577", lat, dout); end
    errs = 0;
    for (int c = 0; c < 20; c++) begin
      din = 16'sh1234; din_valid = c[0];
      @(posedge clk); #1;
      if (dout !== 16'sd8577 || dout_valid !== 1'b1 || din_ready !== 1'b0) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL bp_hold: got %0d bad cycles want 0", errs); end
    din_valid = 1'b1;
    release_out();
    din_valid = 1'b0;
    total++; if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got vld=%b rdy=%b want 0/1", dout_valid, din_ready); end
    @(posedge clk); #1;
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL bp_no_capture: got rdy=%b want 1", din_ready); end
  endtask

  task automatic test_mid_reset();
    int lat;
    logic leak;
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL mr_ready: got %b want 1", din_ready); end
    din = 16'sd16384; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    total++; if (dout_valid !== 1'b0 || din_ready !== 1'b0 || dout !== 16'sd0) begin bad++; $display("FAIL mr_cleared: got vld=%b rdy=%b dout=%0d want 0/0/0", dout_valid, din_ready, dout); end
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL mr_recover_ready: got %b want 1", din_ready); end
    send(16'sd16384, 1'b0, lat, leak);
    total++; if (lat != 13 || dout !== 16'sd8577) begin bad++; $display("FAIL mr_fresh: got lat=%0d dout=%0d want 13/8577", lat, dout); end
    release_out();
  endtask

  task automatic test_bypass();
    int lat;
    logic leak;
    send(16'sd16384, 1'b1, lat, leak);
    total++; if (lat != 1 || dout !== 16'sd8192) begin bad++; $display("FAIL byp_pos: got lat=%0d dout=%0d want 1/8192", lat, dout); end
    release_out();
    send(-16'sd16384, 1'b1, lat, leak);
    total++; if (lat != 1 || dout !== -16'sd8192) begin bad++; $display("FAIL byp_neg: got lat=%0d dout=%0d want 1/-8192", lat, dout); end
    enable = 1'b0;
    @(posedge clk); #1;
    total++; if (dout_valid !== 1'b0 || din_ready !== 1'b0 || dout !== 16'sd0) begin bad++; $display("FAIL byp_disable: got vld=%b rdy=%b dout=%0d want 0/0/0", dout_valid, din_ready, dout); end
    enable = 1'b1;
    @(posedge clk); #1;
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL byp_reenable: got %b want 1", din_ready); end
  endtask

  initial begin
    test_reset();
    test_series();
    test_backpressure();
    test_mid_reset();
    test_bypass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arcsine_taylor.md
Name: arcsine_taylor

Overview:
Streaming fixed-point arcsine estimator. It is the inverse-function counterpart to the team's sine Taylor-series engine.
- Accepts one signed sample x in Q1.(G_DWIDTH-1) over a valid/ready handshake.
- Evaluates the 4-term Maclaurin series asin(x) ≈ x + x³/6 + 3x⁵/40 + 15x⁷/336 iteratively with one shared multiplier.
- Returns the result in Q2.(G_DWIDTH-2) radians.
- Sits downstream of the sine block in phase-recovery and waveshaping paths.

Parameters:
- G_DWIDTH, 16, data width of din/dout (signed).
- G_TAPWIDTH, 16, coefficient width; coefficients are Q2.(G_TAPWIDTH-2).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-low; reset=0 clears the block on the next clk edge.
- enable  in  1  0 = held in reset state (same effect as reset=0).
- bypass  in  1  1 = pass-through mode (see Behaviour); sampled only in S_GET_INPUT.
- din  in  G_DWIDTH  signed x, Q1.(G_DWIDTH-1).
- din_valid  in  1  upstream valid.
- din_ready  out  1  block can accept din.
- dout  out  G_DWIDTH  signed asin(x), Q2.(G_DWIDTH-2).
- dout_valid  out  1  dout holds a result.
- dout_ready  in  1  downstream ready.

Behaviour:
- Reset / enable=0 values: din_ready=0, dout_valid=0, dout=0, acc=0, term index k=0, state=S_INIT. This takes priority over every other event, including a mid-computation reset, which discards the sample.
- S_INIT: drive din_ready=1, go to S_GET_INPUT.
- S_GET_INPUT: on din_valid & din_ready, perform the following, then go to S_SQUARE (bypass=0) or S_BYPASS (bypass=1):
  - din_ready→0
  - x←din, p←din
  - acc←0, k←0
- S_BYPASS: dout←din>>>1 (Q1 to Q2 rescale), dout_valid←1, go to S_SEND_OUTPUT. Latency is 1 edge.
- S_SQUARE: x2←(x·x)>>>(G_DWIDTH-1). The product is full width 2·G_DWIDTH; the shift is arithmetic; keep G_DWIDTH+1 bits.
- S_MULT: term←p·coef[k]. Full width G_DWIDTH+G_TAPWIDTH.
- S_ACCUM:
  - acc←acc+term, where acc is G_DWIDTH+G_TAPWIDTH+2 bits signed.
  - If k==3, go to S_RESCALE; else k←k+1 and go to S_NEXT_POWER.
- S_NEXT_POWER: p←(p·x2)>>>(G_DWIDTH-1), go to S_MULT.
- S_RESCALE:
  - dout←sat(acc>>>(G_TAPWIDTH-1)), where sat clamps to the signed G_DWIDTH range.
  - The shift is arithmetic (truncation toward −∞); there is no rounding.
  - dout_valid←1, go to S_SEND_OUTPUT.
- Latency: with the accepting edge as E0, dout_valid rises at edge E13 (bypass path: E1).
- S_SEND_OUTPUT: hold dout and dout_valid stable until dout_valid & dout_ready. On that edge, dout_valid←0 and din_ready←1, then go to S_GET_INPUT. No new sample is taken in the same cycle.
- Backpressure: din_ready stays 0 for the entire computation and output hold. Throughput is at most 1 sample per 15 cycles.
- Coefficients: coef[k] = round(c_k·2^(G_TAPWIDTH-2)), with c = {1, 1/6, 3/40, 15/336}. For G_TAPWIDTH=16 this gives {16384, 2731, 1229, 731}.
- Domain: the full input range [-1, 1) is accepted. Near |x|→1 the 4-term series underestimates; this is accepted and no error is flagged.
- dout_ready while dout_valid=0 is ignored. din_valid while din_ready=0 is ignored.

Decomposition:
- Package taylor_pkg holds:
  - the state enum
  - C_ASIN_TERMS=4
  - the real coefficient list and a function returning the quantised coefficient for (k, G_TAPWIDTH)
  - the saturate function
- No sub-module: the single shared signed multiplier is inferred in the FSM body. The sine block can later adopt taylor_pkg.

Test Plan (G_DWIDTH=16, G_TAPWIDTH=16; golden model is a bit-exact integer model of the steps above):
- x=0 → dout=0, dout_valid rising 13 edges after acceptance, din_ready low throughout.
- x=16384 (0.5) → dout bit-exact to the model, within ±2 of 8577; x=−16384 → within ±2 of −8577.
- x=−32768 (−1.0) → no saturation, dout within ±4 of −21075 (series value −1.2863).
- dout_ready held 0 for 20 cycles after dout_valid → dout stable, din_ready=0, din_valid pulses ignored; on release, one handshake, then din_ready=1.
- reset=0 asserted at the 6th cycle of a computation → next edge dout_valid=0, din_ready=0; one cycle after release din_ready=1, and a fresh x=16384 yields the correct result.
- bypass=1, x=16384 → dout=8192 with dout_valid at E1; enable=0 mid-output → dout_valid=0 on the next edge.
